// File: rtl/sad_mem_responder_if.sv
// Engine and host signal bundle for the SAD memory responder.
// master = engine/host side, slave = responder side.
interface sad_mem_responder_if #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int C_ADDR_W = 7,
    parameter int RES_W    = 32
);
    logic                I_En;
    logic                I_RW;
    logic [ADDR_W-1:0]   A_Addr;
    logic [ADDR_W-1:0]   B_Addr;
    logic [DATA_W-1:0]   A_Data;
    logic [DATA_W-1:0]   B_Data;
    logic                O_En;
    logic                O_RW;
    logic [C_ADDR_W-1:0] C_Addr;
    logic [RES_W-1:0]    SAD_In;
    logic                H_WrEn;
    logic                H_Sel;
    logic [ADDR_W-1:0]   H_Addr;
    logic [DATA_W-1:0]   H_WData;
    logic                H_Clr;
    logic                H_RdReq;
    logic [C_ADDR_W-1:0] H_RdIdx;
    logic                H_RdValid;
    logic [RES_W-1:0]    H_RdData;
    logic                H_RdHit;
    logic [C_ADDR_W:0]   Res_Count;
    logic                Frame_Done;
    logic                Err;

    modport master (
        output I_En, I_RW, A_Addr, B_Addr, O_En, O_RW, C_Addr, SAD_In,
               H_WrEn, H_Sel, H_Addr, H_WData, H_Clr, H_RdReq, H_RdIdx,
        input  A_Data, B_Data, H_RdValid, H_RdData, H_RdHit, Res_Count,
               Frame_Done, Err
    );

    modport slave (
        input  I_En, I_RW, A_Addr, B_Addr, O_En, O_RW, C_Addr, SAD_In,
               H_WrEn, H_Sel, H_Addr, H_WData, H_Clr, H_RdReq, H_RdIdx,
        output A_Data, B_Data, H_RdValid, H_RdData, H_RdHit, Res_Count,
               Frame_Done, Err
    );
endinterface

// File: rtl/sad_mem_responder.sv
// Memory-side responder for the SAD engine: frame buffers A/B with a pipelined
// read port, a result store with valid tracking, and a host load/readback port.
module sad_mem_responder #(
    parameter int ADDR_W   = 15,
    parameter int DATA_W   = 8,
    parameter int C_ADDR_W = 7,
    parameter int RES_W    = 32,
    parameter int RD_LAT   = 2
) (
    input  logic                  Clk,
    input  logic                  Rst,
    sad_mem_responder_if.slave    bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned N_RES = 1 << C_ADDR_W;
    localparam logic [C_ADDR_W:0] FULL    = {1'b1, {C_ADDR_W{1'b0}}};
    localparam logic [C_ADDR_W:0] CNT_ONE = {{C_ADDR_W{1'b0}}, 1'b1};
    localparam bit LAT1 = (RD_LAT == 1);

    logic [DATA_W-1:0] a_mem [DEPTH];
    logic [DATA_W-1:0] b_mem [DEPTH];
    logic [RES_W-1:0]  r_mem [N_RES];

    logic rd_acc, res_wr, err_set;

    logic              vld1_q, vld1_d, vld2_q, vld2_d;
    logic [DATA_W-1:0] a_s1_q, a_s1_d, b_s1_q, b_s1_d;
    logic [DATA_W-1:0] a_s2_q, a_s2_d, b_s2_q, b_s2_d;
    logic [DATA_W-1:0] a_data_q, a_data_d, b_data_q, b_data_d;
    logic [N_RES-1:0]  res_vld_q, res_vld_d;
    logic [C_ADDR_W:0] res_cnt_q, res_cnt_d;
    logic              done_q, done_d, done_sent_q, done_sent_d;
    logic              err_q, err_d;
    logic              hrd_vld_q, hrd_vld_d, hrd_hit_q, hrd_hit_d;
    logic [RES_W-1:0]  hrd_data_q, hrd_data_d;

    // Any flagged engine request, including a read overlapping a result write, is not served.
    always_comb begin
        res_wr  = bus.O_En && bus.O_RW;
        rd_acc  = bus.I_En && !bus.I_RW && !res_wr;
        err_set = bus.I_En && (bus.I_RW || res_wr);
    end

    // Buffers sample before the host write lands, so same-cycle reads see the old byte.
    always_comb begin
        vld1_d   = rd_acc;
        a_s1_d   = rd_acc ? a_mem[bus.A_Addr] : a_s1_q;
        b_s1_d   = rd_acc ? b_mem[bus.B_Addr] : b_s1_q;
        vld2_d   = vld1_q;
        a_s2_d   = vld1_q ? a_s1_q : a_s2_q;
        b_s2_d   = vld1_q ? b_s1_q : b_s2_q;
        a_data_d = a_data_q;
        b_data_d = b_data_q;
        if (LAT1) begin
            if (vld1_q) begin
                a_data_d = a_s1_q;
                b_data_d = b_s1_q;
            end
        end else if (vld2_q) begin
            a_data_d = a_s2_q;
            b_data_d = b_s2_q;
        end
    end

    always_comb begin
        res_vld_d   = res_vld_q;
        res_cnt_d   = res_cnt_q;
        done_sent_d = done_sent_q;
        err_d       = err_q || err_set;
        if (res_wr) begin
            res_vld_d[bus.C_Addr] = 1'b1;
            if (!res_vld_q[bus.C_Addr] && res_cnt_q != FULL)
                res_cnt_d = res_cnt_q + CNT_ONE;
        end
        // done_sent arms a single pulse per clear once the count has settled at FULL.
        done_d = (res_cnt_q == FULL) && !done_sent_q;
        if (done_d)
            done_sent_d = 1'b1;
        if (bus.H_Clr) begin
            res_vld_d   = '0;
            res_cnt_d   = '0;
            err_d       = 1'b0;
            done_d      = 1'b0;
            done_sent_d = 1'b0;
        end
        hrd_vld_d  = bus.H_RdReq;
        hrd_data_d = bus.H_RdReq ? r_mem[bus.H_RdIdx]     : hrd_data_q;
        hrd_hit_d  = bus.H_RdReq ? res_vld_q[bus.H_RdIdx] : hrd_hit_q;
    end

    always_ff @(posedge Clk) begin
        if (bus.H_WrEn) begin
            if (bus.H_Sel)
                b_mem[bus.H_Addr] <= bus.H_WData;
            else
                a_mem[bus.H_Addr] <= bus.H_WData;
        end
        if (res_wr)
            r_mem[bus.C_Addr] <= bus.SAD_In;
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            vld1_q      <= 1'b0;
            vld2_q      <= 1'b0;
            a_s1_q      <= '0;
            b_s1_q      <= '0;
            a_s2_q      <= '0;
            b_s2_q      <= '0;
            a_data_q    <= '0;
            b_data_q    <= '0;
            res_vld_q   <= '0;
            res_cnt_q   <= '0;
            done_q      <= 1'b0;
            done_sent_q <= 1'b0;
            err_q       <= 1'b0;
            hrd_vld_q   <= 1'b0;
            hrd_hit_q   <= 1'b0;
            hrd_data_q  <= '0;
        end else begin
            vld1_q      <= vld1_d;
            vld2_q      <= vld2_d;
            a_s1_q      <= a_s1_d;
            b_s1_q      <= b_s1_d;
            a_s2_q      <= a_s2_d;
            b_s2_q      <= b_s2_d;
            a_data_q    <= a_data_d;
            b_data_q    <= b_data_d;
            res_vld_q   <= res_vld_d;
            res_cnt_q   <= res_cnt_d;
            done_q      <= done_d;
            done_sent_q <= done_sent_d;
            err_q       <= err_d;
            hrd_vld_q   <= hrd_vld_d;
            hrd_hit_q   <= hrd_hit_d;
            hrd_data_q  <= hrd_data_d;
        end
    end

    assign bus.A_Data     = a_data_q;
    assign bus.B_Data     = b_data_q;
    assign bus.H_RdValid  = hrd_vld_q;
    assign bus.H_RdData   = hrd_data_q;
    assign bus.H_RdHit    = hrd_hit_q;
    assign bus.Res_Count  = res_cnt_q;
    assign bus.Frame_Done = done_q;
    assign bus.Err        = err_q;
endmodule

// File: tb/tb_sad_mem_responder.sv
// Scoreboard bench for sad_mem_responder: buffer reads, result store, frame
// completion, protocol errors and reset during an in-flight read.
module tb_sad_mem_responder;
    localparam int ADDR_W   = 15;
    localparam int DATA_W   = 8;
    localparam int C_ADDR_W = 7;
    localparam int RES_W    = 32;
    localparam int RD_LAT   = 2;
    localparam int N_RES    = 1 << C_ADDR_W;

    logic Clk = 1'b0;
    logic Rst = 1'b0;
    always #5 Clk = ~Clk;

    sad_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .C_ADDR_W(C_ADDR_W), .RES_W(RES_W)) bus ();

    sad_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .C_ADDR_W(C_ADDR_W), .RES_W(RES_W), .RD_LAT(RD_LAT)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    typedef struct { logic [DATA_W-1:0] a; logic [DATA_W-1:0] b; } rd_exp_t;
    typedef struct { logic [RES_W-1:0] data; logic hit; } hr_exp_t;

    rd_exp_t rd_q[$];
    hr_exp_t hr_q[$];
    logic [DATA_W-1:0] a_model [int];
    logic [DATA_W-1:0] b_model [int];
    logic [DATA_W-1:0] last_a = '0;
    logic [DATA_W-1:0] last_b = '0;
    int unsigned pass_cnt  = 0;
    int unsigned total_cnt = 0;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic idle();
        bus.I_En = 1'b0;  bus.I_RW = 1'b0;  bus.A_Addr = '0;  bus.B_Addr = '0;
        bus.O_En = 1'b0;  bus.O_RW = 1'b0;  bus.C_Addr = '0;  bus.SAD_In = '0;
        bus.H_WrEn = 1'b0; bus.H_Sel = 1'b0; bus.H_Addr = '0; bus.H_WData = '0;
        bus.H_Clr = 1'b0; bus.H_RdReq = 1'b0; bus.H_RdIdx = '0;
    endtask

    task automatic drive_hwr(input logic sel, input int addr, input logic [DATA_W-1:0] data);
        bus.H_WrEn = 1'b1; bus.H_Sel = sel; bus.H_Addr = ADDR_W'(addr); bus.H_WData = data;
        if (sel) b_model[addr] = data;
        else     a_model[addr] = data;
    endtask

    task automatic host_wr(input logic sel, input int addr, input logic [DATA_W-1:0] data);
        drive_hwr(sel, addr, data);
        tick();
        bus.H_WrEn = 1'b0;
    endtask

    // Expectation is taken from the model before any same-cycle host write updates it.
    task automatic set_read(input int a_addr, input int b_addr);
        rd_exp_t e;
        e.a = a_model[a_addr];
        e.b = b_model[b_addr];
        rd_q.push_back(e);
        bus.I_En = 1'b1; bus.I_RW = 1'b0;
        bus.A_Addr = ADDR_W'(a_addr); bus.B_Addr = ADDR_W'(b_addr);
    endtask

    task automatic res_wr(input int idx, input logic [RES_W-1:0] val);
        bus.O_En = 1'b1; bus.O_RW = 1'b1; bus.C_Addr = C_ADDR_W'(idx); bus.SAD_In = val;
        tick();
        bus.O_En = 1'b0; bus.O_RW = 1'b0;
    endtask

    task automatic host_read(input int idx, output logic [RES_W-1:0] d, output logic h, output logic ok);
        bus.H_RdReq = 1'b1; bus.H_RdIdx = C_ADDR_W'(idx);
        tick();
        bus.H_RdReq = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.H_RdValid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        d = bus.H_RdData;
        h = bus.H_RdHit;
    endtask

    task automatic test_reset();
        idle();
        Rst = 1'b0;
        repeat (3) tick();
        total_cnt++; if (bus.A_Data !== '0) $display("FAIL rst_a_data: got %h want 00", bus.A_Data); else pass_cnt++;
        total_cnt++; if (bus.B_Data !== '0) $display("FAIL rst_b_data: got %h want 00", bus.B_Data); else pass_cnt++;
        total_cnt++; if (bus.H_RdValid !== 1'b0) $display("FAIL rst_rdvalid: got %b want 0", bus.H_RdValid); else pass_cnt++;
        total_cnt++; if (bus.H_RdData !== '0) $display("FAIL rst_rddata: got %h want 0", bus.H_RdData); else pass_cnt++;
        total_cnt++; if (bus.H_RdHit !== 1'b0) $display("FAIL rst_rdhit: got %b want 0", bus.H_RdHit); else pass_cnt++;
        total_cnt++; if (bus.Res_Count !== '0) $display("FAIL rst_count: got %0d want 0", bus.Res_Count); else pass_cnt++;
        total_cnt++; if (bus.Frame_Done !== 1'b0) $display("FAIL rst_done: got %b want 0", bus.Frame_Done); else pass_cnt++;
        total_cnt++; if (bus.Err !== 1'b0) $display("FAIL rst_err: got %b want 0", bus.Err); else pass_cnt++;
        Rst = 1'b1;
        tick();
    endtask

    task automatic test_read();
        rd_exp_t e;
        host_wr(1'b0, 5, 8'h30);
        host_wr(1'b1, 5, 8'h10);
        set_read(5, 5);
        tick();
        bus.I_En = 1'b0;
        for (int k = 0; k < RD_LAT; k++) begin
            total_cnt++;
            if (bus.A_Data !== last_a) $display("FAIL t1_early_%0d: got %h want %h", k, bus.A_Data, last_a); else pass_cnt++;
            tick();
        end
        e = rd_q.pop_front();
        total_cnt++; if (bus.A_Data !== e.a) $display("FAIL t1_a_data: got %h want %h", bus.A_Data, e.a); else pass_cnt++;
        total_cnt++; if (bus.B_Data !== e.b) $display("FAIL t1_b_data: got %h want %h", bus.B_Data, e.b); else pass_cnt++;
        last_a = e.a; last_b = e.b;

        set_read(5, 5);
        drive_hwr(1'b0, 5, 8'h77);
        tick();
        bus.I_En = 1'b0; bus.H_WrEn = 1'b0;
        repeat (RD_LAT) tick();
        e = rd_q.pop_front();
        total_cnt++; if (bus.A_Data !== e.a) $display("FAIL t1_read_first: got %h want %h", bus.A_Data, e.a); else pass_cnt++;

        set_read(5, 5);
        tick();
        bus.I_En = 1'b0;
        repeat (RD_LAT) tick();
        e = rd_q.pop_front();
        total_cnt++; if (bus.A_Data !== e.a) $display("FAIL t1_new_byte: got %h want %h", bus.A_Data, e.a); else pass_cnt++;
        last_a = e.a; last_b = e.b;
    endtask

    task automatic test_back_to_back();
        rd_exp_t e;
        for (int i = 0; i < 3; i++) begin
            host_wr(1'b0, i, DATA_W'(8'hA0 + i));
            host_wr(1'b1, i, DATA_W'(8'hB0 + i));
        end
        for (int i = 0; i < 3 + RD_LAT; i++) begin
            if (i < 3) set_read(i, 2 - i);
            else       bus.I_En = 1'b0;
            tick();
            if (i >= RD_LAT) begin
                e = rd_q.pop_front();
                total_cnt++;
                if (bus.A_Data !== e.a || bus.B_Data !== e.b)
                    $display("FAIL t2_b2b_%0d: got %h/%h want %h/%h", i - RD_LAT, bus.A_Data, bus.B_Data, e.a, e.b);
                else pass_cnt++;
                last_a = e.a; last_b = e.b;
            end
        end
    endtask

    task automatic test_result();
        hr_exp_t e;
        logic [RES_W-1:0] d;
        logic h, ok;
        res_wr(3, 32'h1234);
        total_cnt++; if (bus.Res_Count !== 8'd1) $display("FAIL t3_count: got %0d want 1", bus.Res_Count); else pass_cnt++;
        hr_q.push_back('{32'h1234, 1'b1});
        host_read(3, d, h, ok);
        e = hr_q.pop_front();
        total_cnt++;
        if (!ok || d !== e.data || h !== e.hit) $display("FAIL t3_read: valid=%b data=%h hit=%b want data=%h hit=%b", ok, d, h, e.data, e.hit);
        else pass_cnt++;
        tick();
        total_cnt++; if (bus.H_RdValid !== 1'b0) $display("FAIL t3_pulse: got %b want 0", bus.H_RdValid); else pass_cnt++;

        res_wr(3, 32'h5678);
        total_cnt++; if (bus.Res_Count !== 8'd1) $display("FAIL t3_rewrite_count: got %0d want 1", bus.Res_Count); else pass_cnt++;

        hr_q.push_back('{32'h5678, 1'b1});
        bus.O_En = 1'b1; bus.O_RW = 1'b1; bus.C_Addr = 7'd3; bus.SAD_In = 32'h9999;
        bus.H_RdReq = 1'b1; bus.H_RdIdx = 7'd3;
        tick();
        bus.O_En = 1'b0; bus.O_RW = 1'b0; bus.H_RdReq = 1'b0;
        e = hr_q.pop_front();
        total_cnt++;
        if (bus.H_RdValid !== 1'b1 || bus.H_RdData !== e.data || bus.H_RdHit !== e.hit)
            $display("FAIL t3_read_first: valid=%b data=%h hit=%b want data=%h hit=%b", bus.H_RdValid, bus.H_RdData, bus.H_RdHit, e.data, e.hit);
        else pass_cnt++;

        bus.O_En = 1'b1; bus.O_RW = 1'b0; bus.C_Addr = 7'd4; bus.SAD_In = 32'hDEAD;
        tick();
        bus.O_En = 1'b0;
        total_cnt++; if (bus.Res_Count !== 8'd1) $display("FAIL t3_read_ignored: got %0d want 1", bus.Res_Count); else pass_cnt++;
        host_read(4, d, h, ok);
        total_cnt++; if (!ok || h !== 1'b0) $display("FAIL t3_no_hit: valid=%b hit=%b want hit=0", ok, h); else pass_cnt++;
    endtask

    task automatic test_frame();
        hr_exp_t e;
        logic [RES_W-1:0] d;
        logic h, ok;
        int pulses;
        bus.H_Clr = 1'b1;
        tick();
        bus.H_Clr = 1'b0;
        total_cnt++; if (bus.Res_Count !== 8'd0) $display("FAIL t4_clr_first: got %0d want 0", bus.Res_Count); else pass_cnt++;
        pulses = 0;
        for (int i = 0; i < N_RES; i++) begin
            bus.O_En = 1'b1; bus.O_RW = 1'b1; bus.C_Addr = C_ADDR_W'(i); bus.SAD_In = RES_W'(32'h1000 + i);
            tick();
            if (bus.Frame_Done === 1'b1) pulses++;
        end
        bus.O_En = 1'b0; bus.O_RW = 1'b0;
        total_cnt++; if (bus.Res_Count !== 8'd128) $display("FAIL t4_full_count: got %0d want 128", bus.Res_Count); else pass_cnt++;
        total_cnt++; if (bus.Frame_Done !== 1'b0) $display("FAIL t4_done_early: got %b want 0", bus.Frame_Done); else pass_cnt++;
        tick();
        total_cnt++; if (bus.Frame_Done !== 1'b1) $display("FAIL t4_done_pulse: got %b want 1", bus.Frame_Done); else pass_cnt++;
        if (bus.Frame_Done === 1'b1) pulses++;
        res_wr(0, 32'h1000);
        if (bus.Frame_Done === 1'b1) pulses++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.Frame_Done === 1'b1) pulses++;
        end
        total_cnt++; if (bus.Res_Count !== 8'd128) $display("FAIL t4_saturate: got %0d want 128", bus.Res_Count); else pass_cnt++;
        total_cnt++; if (pulses != 1) $display("FAIL t4_pulse_count: got %0d want 1", pulses); else pass_cnt++;

        bus.H_Clr = 1'b1;
        tick();
        bus.H_Clr = 1'b0;
        total_cnt++; if (bus.Res_Count !== 8'd0) $display("FAIL t4_clr_count: got %0d want 0", bus.Res_Count); else pass_cnt++;
        for (int i = 0; i < N_RES; i++) begin
            hr_q.push_back('{RES_W'(32'h1000 + i), 1'b0});
            host_read(i, d, h, ok);
            e = hr_q.pop_front();
            total_cnt++;
            if (!ok || d !== e.data || h !== e.hit) $display("FAIL t4_clr_idx%0d: valid=%b data=%h hit=%b want data=%h hit=%b", i, ok, d, h, e.data, e.hit);
            else pass_cnt++;
        end

        bus.H_Clr = 1'b1;
        bus.O_En = 1'b1; bus.O_RW = 1'b1; bus.C_Addr = 7'd7; bus.SAD_In = 32'hAAAA;
        tick();
        bus.H_Clr = 1'b0; bus.O_En = 1'b0; bus.O_RW = 1'b0;
        total_cnt++; if (bus.Res_Count !== 8'd0) $display("FAIL t4_clr_prio_count: got %0d want 0", bus.Res_Count); else pass_cnt++;
        hr_q.push_back('{32'hAAAA, 1'b0});
        host_read(7, d, h, ok);
        e = hr_q.pop_front();
        total_cnt++;
        if (!ok || d !== e.data || h !== e.hit) $display("FAIL t4_clr_prio: valid=%b data=%h hit=%b want data=%h hit=%b", ok, d, h, e.data, e.hit);
        else pass_cnt++;
    endtask

    task automatic test_err();
        bus.I_En = 1'b1; bus.I_RW = 1'b1; bus.A_Addr = 15'd5; bus.B_Addr = 15'd5;
        tick();
        bus.I_En = 1'b0; bus.I_RW = 1'b0;
        total_cnt++; if (bus.Err !== 1'b1) $display("FAIL t5_err_set: got %b want 1", bus.Err); else pass_cnt++;
        repeat (RD_LAT + 2) tick();
        total_cnt++; if (bus.Err !== 1'b1) $display("FAIL t5_err_held: got %b want 1", bus.Err); else pass_cnt++;
        total_cnt++;
        if (bus.A_Data !== last_a || bus.B_Data !== last_b) $display("FAIL t5_no_read: got %h/%h want %h/%h", bus.A_Data, bus.B_Data, last_a, last_b);
        else pass_cnt++;
        bus.H_Clr = 1'b1;
        tick();
        bus.H_Clr = 1'b0;
        total_cnt++; if (bus.Err !== 1'b0) $display("FAIL t5_err_clr: got %b want 0", bus.Err); else pass_cnt++;

        bus.I_En = 1'b1; bus.I_RW = 1'b0; bus.A_Addr = 15'd0; bus.B_Addr = 15'd0;
        bus.O_En = 1'b1; bus.O_RW = 1'b1; bus.C_Addr = 7'd9; bus.SAD_In = 32'h0;
        tick();
        idle();
        total_cnt++; if (bus.Err !== 1'b1) $display("FAIL t5_overlap_err: got %b want 1", bus.Err); else pass_cnt++;
        repeat (RD_LAT + 1) tick();
        total_cnt++;
        if (bus.A_Data !== last_a || bus.B_Data !== last_b) $display("FAIL t5_overlap_no_read: got %h/%h want %h/%h", bus.A_Data, bus.B_Data, last_a, last_b);
        else pass_cnt++;
        bus.H_Clr = 1'b1;
        tick();
        bus.H_Clr = 1'b0;
    endtask

    task automatic test_reset_midread();
        rd_exp_t e;
        res_wr(1, 32'h55);
        total_cnt++; if (bus.Res_Count !== 8'd1) $display("FAIL t6_pre_count: got %0d want 1", bus.Res_Count); else pass_cnt++;
        bus.I_En = 1'b1; bus.A_Addr = 15'd1; bus.B_Addr = 15'd1;
        tick();
        bus.I_En = 1'b0;
        #2;
        Rst = 1'b0;
        #1;
        total_cnt++;
        if (bus.A_Data !== '0 || bus.B_Data !== '0) $display("FAIL t6_async_data: got %h/%h want 00/00", bus.A_Data, bus.B_Data);
        else pass_cnt++;
        total_cnt++; if (bus.Res_Count !== '0) $display("FAIL t6_async_count: got %0d want 0", bus.Res_Count); else pass_cnt++;
        tick();
        tick();
        Rst = 1'b1;
        repeat (RD_LAT + 2) tick();
        total_cnt++;
        if (bus.A_Data !== '0 || bus.B_Data !== '0) $display("FAIL t6_no_late: got %h/%h want 00/00", bus.A_Data, bus.B_Data);
        else pass_cnt++;
        set_read(5, 5);
        tick();
        bus.I_En = 1'b0;
        repeat (RD_LAT) tick();
        e = rd_q.pop_front();
        total_cnt++;
        if (bus.A_Data !== e.a || bus.B_Data !== e.b) $display("FAIL t6_ram_kept: got %h/%h want %h/%h", bus.A_Data, bus.B_Data, e.a, e.b);
        else pass_cnt++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_result();
        test_frame();
        test_err();
        test_reset_midread();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
